pong_ball_engine: RTL
=====================

Name: pong_ball_engine

Overview:
- Producer side of the packed 32-bit `ball` bus that the VGA display path consumes.
- Runs ball motion, wall and paddle collisions, point scoring and serve sequencing on a divided game tick.
- Consumes paddle y positions and a serve request; drives the ball word, score events and game-over.
- Sits between the button/guitar input logic and the display controller.

Parameters:
- SCREEN_W, 640, visible width in pixels
- SCREEN_H, 480, visible height in pixels
- BALL_SIZE, 20, ball edge length in pixels
- PADDLE_W, 20, paddle width
- PADDLE_H, 100, paddle height
- PL_X, 100, left paddle left edge x
- PR_X, 500, right paddle left edge x
- BALL_VEL, 3, pixels moved per tick on each axis
- TICK_DIV, 420000, iVGA_CLK cycles per game tick
- HOLD_TICKS, 30, ticks the ball is held after a point
- WIN_SCORE, 7, score that ends the game

Ports:
- iVGA_CLK  in  1  sole clock
- iRST_n  in  1  asynchronous active-low reset
- pL_ypos  in  12  left paddle top y (unsigned)
- pR_ypos  in  12  right paddle top y (unsigned)
- serve  in  1  level/pulse serve request, sampled every cycle
- ball  out  32  [31:21] x, [20:10] y, [9] dx (1=right), [8] dy (1=down), [7:4] left score, [3:0] right score
- score_evt  out  2  one-cycle pulse: [1] left scored, [0] right scored
- game_tick  out  1  one-cycle pulse on each tick
- game_over  out  1  high in GAME_OVER state

Behaviour:
Reset (async assert, sync release):
- state IDLE, tick counter 0
- ball = {11'd310, 11'd230, 1, 1, 4'd0, 4'd0}
- score_evt = 0, game_tick = 0, game_over = 0
- serve-direction register: dx=1, dy=1

Tick generation:
- Counter runs 0..TICK_DIV-1 in every state.
- game_tick asserts on the cycle the count equals TICK_DIV-1; the counter wraps to 0 on that same cycle.

States:
- IDLE:
  - Ball held at center (310,230).
  - serve=1 loads dx/dy from the serve-direction register and moves to MOVE next cycle.
  - First motion occurs on the next game_tick.
- MOVE, evaluated only on game_tick using current x,y,dx,dy. Axes are handled independently in the same tick.
  - Y axis:
    - If dy=0 and y<=BALL_VEL: y<=0, dy<=1.
    - Else if dy=1 and y+BALL_SIZE+BALL_VEL>=SCREEN_H: y<=SCREEN_H-BALL_SIZE, dy<=0.
    - Else y moves by BALL_VEL.
  - X axis, left-moving:
    - If x>=PL_X+PADDLE_W, x-BALL_VEL<=PL_X+PADDLE_W, y+BALL_SIZE>pL_ypos and y<pL_ypos+PADDLE_H: x<=PL_X+PADDLE_W, dx<=1 (paddle hit).
    - Else if x<=BALL_VEL: right scores.
    - Else x-=BALL_VEL.
  - X axis, right-moving:
    - Paddle hit when x+BALL_SIZE<=PR_X, x+BALL_SIZE+BALL_VEL>=PR_X and y overlaps pR_ypos: x<=PR_X-BALL_SIZE, dx<=0.
    - Else if x+BALL_SIZE+BALL_VEL>=SCREEN_W: left scores.
    - Else x+=BALL_VEL.
  - On a score:
    - Increment that score; saturate at 15.
    - Pulse the matching score_evt bit for one cycle.
    - x,y freeze at pre-tick values.
    - Serve-direction dx <= toward the conceding player; dy toggles.
    - Enter SCORED.
  - A paddle hit takes priority over a miss in the same tick.
- SCORED:
  - Hold HOLD_TICKS ticks.
  - If either score >= WIN_SCORE, go to GAME_OVER; else re-center the ball and go to IDLE.
- GAME_OVER:
  - game_over=1; ball frozen.
  - serve=1 clears both scores, re-centers, and goes to IDLE (a new serve is still required).
- serve is ignored in MOVE and SCORED.

Arithmetic and output rules:
- All compares are done on 12-bit zero-extended operands so no add wraps.
- Paddle inputs are used as given, without clamping.
- ball[9:8] always reflect the current dx/dy.
- ball is registered; it updates the cycle after the tick.
- Reset mid-operation returns to the reset values immediately and asynchronously.

Test Plan (TICK_DIV=4, HOLD_TICKS=2, WIN_SCORE=2 in bench):
- Reset, then serve pulse: IDLE->MOVE; after the first tick ball x=313, y=233, dx=1, dy=1; game_tick period is exactly 4 cycles.
- Force x=400, y=458, dy=1, dx=1, tick: y=460, dy=0, x=403 (bottom wall clamp and bounce).
- Force x=477, dx=1, pR_ypos=200, y=250, tick: x=480, dx=0, no score_evt. Repeat with pR_ypos=300: x=480 on the first tick, next ticks pass the paddle until x+23>=640, then score_evt=2'b10 for 1 cycle and left score=1.
- Force x=2, dx=0, paddles away: score_evt=2'b01, right score increments, SCORED held 2 ticks, ball returns to (310,230) in IDLE with next serve dx=0.
- Drive left score to 2: game_over=1 after hold; serve pulse clears scores, game_over=0, state IDLE.
- Assert iRST_n=0 mid-MOVE between clock edges: ball = reset word with no clock edge, score_evt=0.

Source files
------------

// File: rtl/pong_ball_engine.sv
// Ball physics and serve/score sequencing for the pong display path.
// Drives the packed ball word {x, y, dx, dy, left score, right score}.
module pong_ball_engine #(
    parameter int SCREEN_W   = 640,
    parameter int SCREEN_H   = 480,
    parameter int BALL_SIZE  = 20,
    parameter int PADDLE_W   = 20,
    parameter int PADDLE_H   = 100,
    parameter int PL_X       = 100,
    parameter int PR_X       = 500,
    parameter int BALL_VEL   = 3,
    parameter int TICK_DIV   = 420000,
    parameter int HOLD_TICKS = 30,
    parameter int WIN_SCORE  = 7
) (
    input  logic        iVGA_CLK,
    input  logic        iRST_n,
    input  logic [11:0] pL_ypos,
    input  logic [11:0] pR_ypos,
    input  logic        serve,
    output logic [31:0] ball,
    output logic [1:0]  score_evt,
    output logic        game_tick,
    output logic        game_over
);

    localparam int CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HOLD_W = $clog2(HOLD_TICKS + 1);

    localparam logic [11:0] W12     = 12'(SCREEN_W);
    localparam logic [11:0] H12     = 12'(SCREEN_H);
    localparam logic [11:0] SIZE12  = 12'(BALL_SIZE);
    localparam logic [11:0] PH12    = 12'(PADDLE_H);
    localparam logic [11:0] PL_EDGE = 12'(PL_X + PADDLE_W);
    localparam logic [11:0] PR12    = 12'(PR_X);
    localparam logic [11:0] VEL12   = 12'(BALL_VEL);
    localparam logic [10:0] X_CTR   = 11'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [10:0] Y_CTR   = 11'((SCREEN_H - BALL_SIZE) / 2);

    typedef enum logic [1:0] {IDLE, MOVE, SCORED, GAME_OVER} state_t;

    state_t             state_reg, state_next;
    logic [1:0]         rst_sync_reg;
    logic               rst_n;
    logic [CNT_W-1:0]   tick_cnt_reg;
    logic [HOLD_W-1:0]  hold_cnt_reg;
    logic [10:0]        x_reg, y_reg;
    logic               dx_reg, dy_reg;
    logic [3:0]         score_l_reg, score_r_reg;
    logic               serve_dx_reg, serve_dy_reg;
    logic [1:0]         score_evt_reg;

    logic               tick;
    logic               hold_done;
    logic               win;
    logic [11:0]        x12, y12;
    logic [10:0]        x_next, y_next;
    logic               dx_next, dy_next;
    logic               l_hit, r_hit, l_miss, r_miss;

    // Deassertion is retimed to the clock; assertion stays asynchronous.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) rst_sync_reg <= 2'b00;
        else         rst_sync_reg <= {rst_sync_reg[0], 1'b1};
    end
    assign rst_n = rst_sync_reg[1];

    assign tick      = (tick_cnt_reg == CNT_W'(TICK_DIV - 1));
    assign hold_done = (hold_cnt_reg == HOLD_W'(HOLD_TICKS - 1));
    assign win       = (score_l_reg >= 4'(WIN_SCORE)) || (score_r_reg >= 4'(WIN_SCORE));
    assign x12       = {1'b0, x_reg};
    assign y12       = {1'b0, y_reg};

    always_comb begin
        y_next  = y_reg;
        dy_next = dy_reg;
        if (!dy_reg && (y12 <= VEL12)) begin
            y_next  = 11'd0;
            dy_next = 1'b1;
        end else if (dy_reg && (y12 + SIZE12 + VEL12 >= H12)) begin
            y_next  = 11'(H12 - SIZE12);
            dy_next = 1'b0;
        end else if (dy_reg) begin
            y_next = 11'(y12 + VEL12);
        end else begin
            y_next = 11'(y12 - VEL12);
        end
    end

    // A paddle hit masks the miss test, so a hit wins over a miss in one tick.
    always_comb begin
        l_hit = !dx_reg && (x12 >= PL_EDGE) && (x12 - VEL12 <= PL_EDGE)
                && (y12 + SIZE12 > pL_ypos) && (y12 < pL_ypos + PH12);
        r_hit = dx_reg && (x12 + SIZE12 <= PR12) && (x12 + SIZE12 + VEL12 >= PR12)
                && (y12 + SIZE12 > pR_ypos) && (y12 < pR_ypos + PH12);
        l_miss  = !dx_reg && !l_hit && (x12 <= VEL12);
        r_miss  = dx_reg && !r_hit && (x12 + SIZE12 + VEL12 >= W12);
        x_next  = x_reg;
        dx_next = dx_reg;
        if (l_hit) begin
            x_next  = 11'(PL_EDGE);
            dx_next = 1'b1;
        end else if (r_hit) begin
            x_next  = 11'(PR12 - SIZE12);
            dx_next = 1'b0;
        end else if (dx_reg) begin
            x_next = 11'(x12 + VEL12);
        end else begin
            x_next = 11'(x12 - VEL12);
        end
    end

    always_ff @(posedge iVGA_CLK or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:      if (serve) state_next = MOVE;
            MOVE:      if (tick && (l_miss || r_miss)) state_next = SCORED;
            SCORED:    if (tick && hold_done) state_next = win ? GAME_OVER : IDLE;
            GAME_OVER: if (serve) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        game_tick = tick;
        game_over = (state_reg == GAME_OVER);
    end

    always_ff @(posedge iVGA_CLK or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_reg  <= '0;
            hold_cnt_reg  <= '0;
            x_reg         <= X_CTR;
            y_reg         <= Y_CTR;
            dx_reg        <= 1'b1;
            dy_reg        <= 1'b1;
            score_l_reg   <= 4'd0;
            score_r_reg   <= 4'd0;
            serve_dx_reg  <= 1'b1;
            serve_dy_reg  <= 1'b1;
            score_evt_reg <= 2'b00;
        end else begin
            tick_cnt_reg  <= tick ? '0 : tick_cnt_reg + 1'b1;
            score_evt_reg <= 2'b00;
            case (state_reg)
                IDLE: begin
                    x_reg <= X_CTR;
                    y_reg <= Y_CTR;
                    if (serve) begin
                        dx_reg <= serve_dx_reg;
                        dy_reg <= serve_dy_reg;
                    end
                end
                MOVE: if (tick) begin
                    if (r_miss) begin
                        score_l_reg   <= (score_l_reg == 4'hF) ? 4'hF : score_l_reg + 4'd1;
                        score_evt_reg <= 2'b10;
                        serve_dx_reg  <= 1'b1;
                        serve_dy_reg  <= ~serve_dy_reg;
                        hold_cnt_reg  <= '0;
                    end else if (l_miss) begin
                        score_r_reg   <= (score_r_reg == 4'hF) ? 4'hF : score_r_reg + 4'd1;
                        score_evt_reg <= 2'b01;
                        serve_dx_reg  <= 1'b0;
                        serve_dy_reg  <= ~serve_dy_reg;
                        hold_cnt_reg  <= '0;
                    end else begin
                        x_reg  <= x_next;
                        y_reg  <= y_next;
                        dx_reg <= dx_next;
                        dy_reg <= dy_next;
                    end
                end
                SCORED: if (tick) begin
                    if (hold_done) begin
                        hold_cnt_reg <= '0;
                        if (!win) begin
                            x_reg <= X_CTR;
                            y_reg <= Y_CTR;
                        end
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg + 1'b1;
                    end
                end
                GAME_OVER: if (serve) begin
                    score_l_reg <= 4'd0;
                    score_r_reg <= 4'd0;
                    x_reg       <= X_CTR;
                    y_reg       <= Y_CTR;
                end
                default: ;
            endcase
        end
    end

    assign ball      = {x_reg, y_reg, dx_reg, dy_reg, score_l_reg, score_r_reg};
    assign score_evt = score_evt_reg;

endmodule
